// File: rtl/link_test_sequencer.sv
// link_test_sequencer
//   Sequences one PRBS7 link bring-up and BER test on the 64-bit SERDES receive
//   path. It pulses the data-extractor reset, waits for word alignment (with a
//   bounded number of retries), lets the link settle, then sums the checker's
//   per-word bit-error count over a fixed window and reports pass/fail.
//
//   Optional feature macro: LTS_RELOCK_EN
//     defined   - loss of alignment during the measurement window re-enters
//                 WAIT_ALIGN and consumes one retry; the window then resumes.
//     undefined - loss of alignment during the window fails the test at once.
//
// Ports
//   clk         in   1      system clock, rising edge
//   reset_n     in   1      asynchronous active-low reset
//   start       in   1      start a test (only looked at in IDLE)
//   abort       in   1      abandon the test from any state
//   aligned     in   1      extractor word-alignment status
//   err_cnt     in   7      bit errors in the current 64-bit word
//   dext_reset  out  1      active-high reset to the data extractor
//   busy        out  1      high whenever state is not IDLE
//   state       out  3      IDLE=0 RESET=1 WAIT_ALIGN=2 SETTLE=3 MEASURE=4 DONE=5 FAIL=6
//   done        out  1      one-cycle pulse on return to IDLE from DONE/FAIL
//   pass        out  1      result of the last completed test
//   fail_code   out  2      0 none, 1 align timeout, 2 lost lock, 3 BER over threshold
//   retries     out  3      alignment retries used
//   win_err     out  CNT_W  saturating error sum over the window
module link_test_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned ALIGN_TIMEOUT = 4096,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned WINDOW_CYCLES = 1 << 20,
  parameter int unsigned ERR_THRESH    = 0,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             aligned,
  input  logic [6:0]       err_cnt,
  output logic             dext_reset,
  output logic             busy,
  output logic [2:0]       state,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [2:0]       retries,
  output logic [CNT_W-1:0] win_err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RESET      = 3'd1,
    S_WAIT_ALIGN = 3'd2,
    S_SETTLE     = 3'd3,
    S_MEASURE    = 3'd4,
    S_DONE       = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  localparam logic [31:0]      RST_LAST    = 32'(RST_CYCLES - 1);
  localparam logic [31:0]      ALIGN_LAST  = 32'(ALIGN_TIMEOUT - 1);
  localparam logic [31:0]      SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0]      WIN_LAST    = 32'(WINDOW_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] THRESH      = CNT_W'(ERR_THRESH);

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;          // shared RESET / WAIT_ALIGN / SETTLE timer
  logic [31:0]      win_cnt_q, win_cnt_d;  // measurement-window position
  logic             rst_hold_q;            // keeps extractor in reset until first edge after reset_n
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       fc_q, fc_d;
  logic [2:0]       retries_q, retries_d;
  logic [CNT_W-1:0] win_err_q, win_err_d;
  logic [CNT_W-1:0] win_err_sum;

  // Add one word's error count, sticking at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [6:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-6){1'b0}}, b};
    if (s[CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  assign win_err_sum = sat_add(win_err_q, err_cnt);

  // State and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      win_cnt_q  <= '0;
      rst_hold_q <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fc_q       <= 2'd0;
      retries_q  <= 3'd0;
      win_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      win_cnt_q  <= win_cnt_d;
      rst_hold_q <= 1'b0;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fc_q       <= fc_d;
      retries_q  <= retries_d;
      win_err_q  <= win_err_d;
    end
  end

  // Next-state and result update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    win_cnt_d = win_cnt_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    fc_d      = fc_q;
    retries_d = retries_q;
    win_err_d = win_err_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d   = S_RESET;
          win_cnt_d = '0;
          pass_d    = 1'b0;
          fc_d      = 2'd0;
          retries_d = 3'd0;
          win_err_d = '0;
        end
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_ALIGN;
          cnt_d   = '0;
        end
      end
      S_WAIT_ALIGN: begin
        // aligned is checked first so it wins over a coincident timeout
        if (aligned) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == ALIGN_LAST) begin
          cnt_d = '0;
          if (retries_q < RETRY_MAX) begin
            retries_d = retries_q + 3'd1;
            state_d   = S_RESET;
          end else begin
            fc_d    = 2'd1;
            state_d = S_FAIL;
          end
        end
      end
      S_SETTLE: begin
        if (!aligned) begin
          state_d = S_WAIT_ALIGN;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = S_MEASURE;
          cnt_d   = '0;
        end
      end
      S_MEASURE: begin
        // Lost lock is checked before window end so it takes priority on the last cycle.
        if (!aligned) begin
`ifdef LTS_RELOCK_EN
          // win_cnt is left alone so the window resumes after re-settling.
          if (retries_q < RETRY_MAX) begin
            retries_d = retries_q + 3'd1;
            state_d   = S_WAIT_ALIGN;
            cnt_d     = '0;
          end else begin
            fc_d    = 2'd2;
            state_d = S_FAIL;
          end
`else
          fc_d    = 2'd2;
          state_d = S_FAIL;
`endif
        end else begin
          win_err_d = win_err_sum;
          if (win_cnt_q == WIN_LAST) begin
            pass_d = (win_err_sum <= THRESH);
            if (win_err_sum <= THRESH) begin
              state_d = S_DONE;
            end else begin
              fc_d    = 2'd3;
              state_d = S_FAIL;
            end
          end else begin
            win_cnt_d = win_cnt_q + 32'd1;
          end
        end
      end
      S_DONE, S_FAIL: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything outside IDLE; diagnostics are kept, pass is cleared.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fc_d      = fc_q;
      retries_d = retries_q;
      win_err_d = win_err_q;
    end
  end

  // Outputs
  always_comb begin
    dext_reset = rst_hold_q || (state_q == S_RESET);
    busy       = (state_q != S_IDLE);
    state      = state_q;
    done       = done_q;
    pass       = pass_q;
    fail_code  = fc_q;
    retries    = retries_q;
    win_err    = win_err_q;
  end

endmodule

// File: tb/tb_link_test_sequencer.sv
// Directed bench for link_test_sequencer, built with small timing parameters
// (SETTLE 8, WINDOW 16, ERR_THRESH 4, CNT_W 8) so every scenario runs quickly.
module tb_link_test_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       aligned;
  logic [6:0] err_cnt;
  logic       dext_reset;
  logic       busy;
  logic [2:0] state;
  logic       done;
  logic       pass;
  logic [1:0] fail_code;
  logic [2:0] retries;
  logic [7:0] win_err;

  int n_total = 0;
  int n_pass  = 0;

  link_test_sequencer #(
    .RST_CYCLES   (16),
    .ALIGN_TIMEOUT(4096),
    .SETTLE_CYCLES(8),
    .WINDOW_CYCLES(16),
    .ERR_THRESH   (4),
    .MAX_RETRIES  (3),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .aligned   (aligned),
    .err_cnt   (err_cnt),
    .dext_reset(dext_reset),
    .busy      (busy),
    .state     (state),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .retries   (retries),
    .win_err   (win_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then return to the falling edge where outputs are sampled
  // and the next inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // From IDLE with aligned=1: start, ride through RESET/WAIT_ALIGN/SETTLE and
  // stop on the falling edge right after MEASURE is entered.
  task automatic to_measure(input string tag, input logic [6:0] settle_err);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    tick();
    err_cnt = settle_err;
    repeat (8) tick();
    err_cnt = 7'd0;
    chk({tag, "_in_measure"}, 32'(state), 4);
    chk({tag, "_settle_ignored"}, 32'(win_err), 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    aligned = 1'b0;
    err_cnt = 7'd0;
    tick();
    tick();

    // Reset values
    chk("rst_state", 32'(state), 0);
    chk("rst_dext_reset", 32'(dext_reset), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_fail_code", 32'(fail_code), 0);
    chk("rst_retries", 32'(retries), 0);
    chk("rst_win_err", 32'(win_err), 0);
    reset_n = 1'b1;
    tick();
    chk("rst_release_dext", 32'(dext_reset), 0);

    // 1: clean pass, alignment 100 cycles after RESET ends
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_reset_state", 32'(state), 1);
    chk("t1_busy", 32'(busy), 1);
    n = 0;
    while (dext_reset && n < 100) begin
      n++;
      tick();
    end
    chk("t1_dext_cycles", 32'(n), 16);
    chk("t1_wait_state", 32'(state), 2);
    repeat (99) tick();
    aligned = 1'b1;
    tick();
    chk("t1_settle_state", 32'(state), 3);
    repeat (8) tick();
    chk("t1_measure_state", 32'(state), 4);
    repeat (16) tick();
    chk("t1_done_state", 32'(state), 5);
    tick();
    chk("t1_done_pulse", 32'(done), 1);
    chk("t1_idle", 32'(state), 0);
    chk("t1_pass", 32'(pass), 1);
    chk("t1_fail_code", 32'(fail_code), 0);
    chk("t1_win_err", 32'(win_err), 0);
    tick();
    chk("t1_done_one_cycle", 32'(done), 0);
    chk("t1_pass_held", 32'(pass), 1);

    // 3: 7 errors/word in SETTLE ignored, 5 single errors in MEASURE > threshold 4
    to_measure("t3", 7'd7);
    chk("t3_pass_cleared", 32'(pass), 0);
    err_cnt = 7'd1;
    repeat (5) tick();
    err_cnt = 7'd0;
    chk("t3_partial_sum", 32'(win_err), 5);
    repeat (11) tick();
    chk("t3_fail_state", 32'(state), 6);
    chk("t3_fail_code", 32'(fail_code), 3);
    tick();
    chk("t3_done_pulse", 32'(done), 1);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_win_err", 32'(win_err), 5);

    // 5: 127 errors every word saturates the 8-bit sum at 255
    to_measure("t5", 7'd0);
    chk("t5_fc_cleared", 32'(fail_code), 0);
    err_cnt = 7'd127;
    repeat (2) tick();
    chk("t5_sum_254", 32'(win_err), 254);
    tick();
    chk("t5_sat_255", 32'(win_err), 255);
    repeat (13) tick();
    chk("t5_fail_state", 32'(state), 6);
    chk("t5_fail_code", 32'(fail_code), 3);
    chk("t5_still_255", 32'(win_err), 255);
    err_cnt = 7'd0;
    tick();
    chk("t5_done_pulse", 32'(done), 1);

    // 4: alignment on the timeout cycle wins, then lock lost at window cycle 10
    aligned = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("t4_wait_state", 32'(state), 2);
    repeat (4095) tick();
    aligned = 1'b1;
    tick();
    chk("t4_align_wins", 32'(state), 3);
    chk("t4_no_retry", 32'(retries), 0);
    repeat (8) tick();
    chk("t4_measure", 32'(state), 4);
    err_cnt = 7'd1;
    repeat (2) tick();
    err_cnt = 7'd0;
    repeat (8) tick();
    aligned = 1'b0;
    tick();
`ifdef LTS_RELOCK_EN
    chk("t4_relock_wait", 32'(state), 2);
    chk("t4_relock_retries", 32'(retries), 1);
    chk("t4_relock_win_err", 32'(win_err), 2);
    aligned = 1'b1;
    tick();
    repeat (8) tick();
    chk("t4_relock_measure", 32'(state), 4);
    repeat (6) tick();
    chk("t4_relock_done", 32'(state), 5);
    tick();
    chk("t4_relock_pulse", 32'(done), 1);
    chk("t4_relock_pass", 32'(pass), 1);
    chk("t4_relock_fc", 32'(fail_code), 0);
    chk("t4_relock_win_final", 32'(win_err), 2);
`else
    chk("t4_lost_fail", 32'(state), 6);
    chk("t4_lost_fc", 32'(fail_code), 2);
    chk("t4_lost_win_err", 32'(win_err), 2);
    tick();
    chk("t4_lost_pulse", 32'(done), 1);
    chk("t4_lost_pass", 32'(pass), 0);
`endif

    // 2: alignment never arrives, four attempts then align-timeout FAIL
    aligned = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_retries_cleared", 32'(retries), 0);
    repeat (4112) tick();
    chk("t2_retry1_reset", 32'(state), 1);
    chk("t2_retry1_count", 32'(retries), 1);
    n = 4112;
    while (!done && n < 20000) begin
      tick();
      n++;
    end
    chk("t2_done_cycles", 32'(n), 16449);
    chk("t2_retries", 32'(retries), 3);
    chk("t2_fail_code", 32'(fail_code), 1);
    chk("t2_pass", 32'(pass), 0);

    // 6a: abort in MEASURE keeps diagnostics, no done pulse
    aligned = 1'b1;
    to_measure("t6", 7'd0);
    err_cnt = 7'd3;
    repeat (2) tick();
    err_cnt = 7'd0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_idle", 32'(state), 0);
    chk("t6_abort_busy", 32'(busy), 0);
    chk("t6_abort_dext", 32'(dext_reset), 0);
    chk("t6_abort_no_done", 32'(done), 0);
    chk("t6_abort_pass", 32'(pass), 0);
    chk("t6_abort_win_err", 32'(win_err), 6);
    tick();
    chk("t6_abort_no_done2", 32'(done), 0);

    // 6b: reset_n pulsed low in SETTLE
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    chk("t6_settle", 32'(state), 3);
    reset_n = 1'b0;
    #1;
    chk("t6_async_state", 32'(state), 0);
    chk("t6_async_dext", 32'(dext_reset), 1);
    chk("t6_async_win_err", 32'(win_err), 0);
    chk("t6_async_busy", 32'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t6_dext_release", 32'(dext_reset), 0);

    // 6c: start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t6_start_abort_state", 32'(state), 0);
    chk("t6_start_abort_dext", 32'(dext_reset), 0);
    tick();
    chk("t6_start_abort_still_idle", 32'(state), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
